// File: rtl/bp_mmu_ptw.sv
// bp_mmu_ptw: Sv39 page-table walker feeding the TLB fill port.
// Ports: clk_i/reset_n_i (async active-low), satp_ppn_i root table,
//   flush_i abort, miss_* request (accepted when !busy_o),
//   mem_req_*/mem_resp_* single-outstanding PTE read port,
//   w_v_o/w_vtag_o/w_entry_o TLB fill, *_page_fault_o fault pulses.
// Macro BP_PTW_SUPERPAGE_EN: when defined, 2M/1G leaves are filled;
//   when undefined, any leaf above level 0 faults.
module bp_mmu_ptw #(
    parameter int vtag_width_p = 27,
    parameter int ptag_width_p = 28,
    parameter int pte_width_p  = 64
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [ptag_width_p-1:0] satp_ppn_i,
    input  logic                    flush_i,
    input  logic                    miss_v_i,
    input  logic [vtag_width_p-1:0] miss_vtag_i,
    input  logic                    miss_instr_i,
    input  logic                    miss_load_i,
    input  logic                    miss_store_i,
    output logic                    busy_o,
    output logic                    mem_req_v_o,
    output logic [ptag_width_p+11:0] mem_req_addr_o,
    input  logic                    mem_req_ready_i,
    input  logic                    mem_resp_v_i,
    input  logic [pte_width_p-1:0]  mem_resp_data_i,
    output logic                    w_v_o,
    output logic [vtag_width_p-1:0] w_vtag_o,
    output logic [ptag_width_p+6:0] w_entry_o,
    output logic                    instr_page_fault_o,
    output logic                    load_page_fault_o,
    output logic                    store_page_fault_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_FILL,
        S_FAULT,
        S_DRAIN
    } state_e;

    state_e state_r, state_n;

    logic [1:0]              level_r, level_n;
    logic [ptag_width_p-1:0] ppn_r, ppn_n;
    logic [vtag_width_p-1:0] vtag_r;
    logic                    is_instr_r;
    logic                    is_load_r;
    logic                    is_store_r;
    logic [ptag_width_p-1:0] leaf_ppn_r;
    logic [4:0]              leaf_perm_r;
    logic                    accept;

    logic                    pte_v, pte_r, pte_w, pte_x, pte_a, pte_d;
    logic [ptag_width_p-1:0] pte_ppn;
    logic                    pte_invalid, pte_leaf;
    logic                    super_bad, leaf_bad;
    logic [ptag_width_p-1:0] lvl_mask;
    logic [ptag_width_p-1:0] fill_ptag;
    logic [8:0]              vpn_sel;
    logic                    gigapage, megapage;
    logic                    handshake;
    logic                    unused_pte_bits;

    assign pte_v   = mem_resp_data_i[0];
    assign pte_r   = mem_resp_data_i[1];
    assign pte_w   = mem_resp_data_i[2];
    assign pte_x   = mem_resp_data_i[3];
    assign pte_a   = mem_resp_data_i[6];
    assign pte_d   = mem_resp_data_i[7];
    assign pte_ppn = mem_resp_data_i[10 +: ptag_width_p];

    // PPN bits above the physical tag, RSW and G play no part in the walk.
    assign unused_pte_bits = ^{mem_resp_data_i[pte_width_p-1:10+ptag_width_p],
                               mem_resp_data_i[9:8],
                               mem_resp_data_i[5]};

    assign pte_invalid = ~pte_v | (~pte_r & pte_w);
    assign pte_leaf    = pte_r | pte_x;

    // Low PPN bits that a leaf at the current level must leave to the vtag.
    always_comb begin
        lvl_mask = '0;
        unique case (level_r)
            2'd2:    lvl_mask = ptag_width_p'(18'h3ffff);
            2'd1:    lvl_mask = ptag_width_p'(9'h1ff);
            default: lvl_mask = '0;
        endcase
    end

    always_comb begin
        vpn_sel = '0;
        unique case (level_r)
            2'd2:    vpn_sel = vtag_r[18 +: 9];
            2'd1:    vpn_sel = vtag_r[9 +: 9];
            default: vpn_sel = vtag_r[0 +: 9];
        endcase
    end

`ifdef BP_PTW_SUPERPAGE_EN
    assign super_bad = |(pte_ppn & lvl_mask);
    assign gigapage  = (level_r == 2'd2);
    assign megapage  = (level_r == 2'd1);
`else
    assign super_bad = (level_r != 2'd0);
    assign gigapage  = 1'b0;
    assign megapage  = 1'b0;
`endif

    assign leaf_bad = ~pte_a | (is_store_r & ~pte_d) | super_bad;

    assign fill_ptag = (leaf_ppn_r & ~lvl_mask)
                     | (ptag_width_p'(vtag_r) & lvl_mask);

    assign handshake = (state_r == S_REQ) & mem_req_ready_i;

    always_comb begin
        state_n = state_r;
        level_n = level_r;
        ppn_n   = ppn_r;
        accept  = 1'b0;
        unique case (state_r)
            S_IDLE: begin
                if (!flush_i && miss_v_i) begin
                    accept  = 1'b1;
                    level_n = 2'd2;
                    ppn_n   = satp_ppn_i;
                    state_n = S_REQ;
                end
            end
            S_REQ: begin
                // A flush on the handshake cycle leaves a read in flight.
                if (flush_i)
                    state_n = handshake ? S_DRAIN : S_IDLE;
                else if (handshake)
                    state_n = S_WAIT;
            end
            S_WAIT: begin
                if (flush_i) begin
                    state_n = mem_resp_v_i ? S_IDLE : S_DRAIN;
                end else if (mem_resp_v_i) begin
                    if (pte_invalid) begin
                        state_n = S_FAULT;
                    end else if (!pte_leaf) begin
                        if (level_r == 2'd0) begin
                            state_n = S_FAULT;
                        end else begin
                            level_n = level_r - 2'd1;
                            ppn_n   = pte_ppn;
                            state_n = S_REQ;
                        end
                    end else begin
                        state_n = leaf_bad ? S_FAULT : S_FILL;
                    end
                end
            end
            S_FILL:  state_n = S_IDLE;
            S_FAULT: state_n = S_IDLE;
            S_DRAIN: begin
                if (mem_resp_v_i)
                    state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= S_IDLE;
            level_r     <= 2'd2;
            ppn_r       <= '0;
            vtag_r      <= '0;
            is_instr_r  <= 1'b0;
            is_load_r   <= 1'b0;
            is_store_r  <= 1'b0;
            leaf_ppn_r  <= '0;
            leaf_perm_r <= '0;
        end else begin
            state_r <= state_n;
            level_r <= level_n;
            ppn_r   <= ppn_n;
            if (accept) begin
                vtag_r     <= miss_vtag_i;
                is_instr_r <= miss_instr_i;
                is_load_r  <= miss_load_i;
                is_store_r <= miss_store_i;
            end
            if (state_r == S_WAIT && mem_resp_v_i) begin
                leaf_ppn_r  <= pte_ppn;
                leaf_perm_r <= {mem_resp_data_i[7], mem_resp_data_i[4:1]};
            end
        end
    end

    assign busy_o      = (state_r != S_IDLE);
    assign mem_req_v_o = (state_r == S_REQ);

    assign mem_req_addr_o = mem_req_v_o ? {ppn_r, vpn_sel, 3'b000} : '0;

    // A flush landing on the FILL/FAULT cycle cancels the pulse.
    assign w_v_o    = (state_r == S_FILL) & ~flush_i;
    assign w_vtag_o = (state_r == S_FILL) ? vtag_r : '0;
    assign w_entry_o = (state_r == S_FILL)
                     ? {fill_ptag, gigapage, megapage, leaf_perm_r}
                     : '0;

    assign instr_page_fault_o = (state_r == S_FAULT) & ~flush_i & is_instr_r;
    assign load_page_fault_o  = (state_r == S_FAULT) & ~flush_i & is_load_r;
    assign store_page_fault_o = (state_r == S_FAULT) & ~flush_i & is_store_r;

endmodule

// File: tb/tb_bp_mmu_ptw.sv
// tb_bp_mmu_ptw: self-checking bench for bp_mmu_ptw.
// Memory responder plus a walk-level reference model over a sparse PTE map.
module tb_bp_mmu_ptw;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [27:0] satp_ppn;
    logic        flush;
    logic        miss_v;
    logic [26:0] miss_vtag;
    logic        miss_instr, miss_load, miss_store;
    logic        busy;
    logic        mem_req_v;
    logic [39:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_v;
    logic [63:0] mem_resp_data;
    logic        w_v;
    logic [26:0] w_vtag;
    logic [34:0] w_entry;
    logic        f_instr, f_load, f_store;

    bp_mmu_ptw dut (
        .clk_i              (clk),
        .reset_n_i          (reset_n),
        .satp_ppn_i         (satp_ppn),
        .flush_i            (flush),
        .miss_v_i           (miss_v),
        .miss_vtag_i        (miss_vtag),
        .miss_instr_i       (miss_instr),
        .miss_load_i        (miss_load),
        .miss_store_i       (miss_store),
        .busy_o             (busy),
        .mem_req_v_o        (mem_req_v),
        .mem_req_addr_o     (mem_req_addr),
        .mem_req_ready_i    (mem_req_ready),
        .mem_resp_v_i       (mem_resp_v),
        .mem_resp_data_i    (mem_resp_data),
        .w_v_o              (w_v),
        .w_vtag_o           (w_vtag),
        .w_entry_o          (w_entry),
        .instr_page_fault_o (f_instr),
        .load_page_fault_o  (f_load),
        .store_page_fault_o (f_store)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] FV = 8'h01, FR = 8'h02, FW = 8'h04;
    localparam logic [7:0] FX = 8'h08, FA = 8'h40, FD = 8'h80;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] mem [logic [39:0]];

    int          cyc = 0;
    int          ready_mode = 0;
    int          resp_delay = 1;
    bit          pend_v = 0;
    int          pend_cnt = 0;
    logic [63:0] pend_data;

    logic [39:0] req_q[$];
    int          n_fill, n_fi, n_fl, n_fs, fill_cyc;
    logic [34:0] fill_entry;
    logic [26:0] fill_vtag;
    bit          obs_busy;
    int          acc, idle_rel;
    bit          timed_out;

    logic [39:0] exp_q[$];
    bit          exp_fault;
    logic [34:0] exp_entry;

    function automatic logic [63:0] rd(input logic [39:0] a);
        return mem.exists(a) ? mem[a] : 64'h0;
    endfunction

    function automatic logic [63:0] mk_pte(input logic [43:0] ppn,
                                           input logic [7:0] fl);
        return {10'b0, ppn, 2'b0, fl};
    endfunction

    task automatic clear_obs();
        req_q.delete();
        n_fill = 0; n_fi = 0; n_fl = 0; n_fs = 0;
        fill_cyc = -1; fill_entry = '0; fill_vtag = '0;
    endtask

    // One clock: drive inputs and responder at negedge, observe #1 later.
    task automatic cycle(input bit miss, input bit fl);
        @(negedge clk);
        miss_v = miss;
        flush  = fl;
        mem_resp_v = 1'b0;
        mem_resp_data = {$urandom, $urandom};
        if (pend_v) begin
            if (pend_cnt == 0) begin
                mem_resp_v = 1'b1;
                mem_resp_data = pend_data;
                pend_v = 0;
            end else begin
                pend_cnt--;
            end
        end
        case (ready_mode)
            0:       mem_req_ready = 1'b1;
            1:       mem_req_ready = 1'($urandom_range(0, 1));
            default: mem_req_ready = 1'b0;
        endcase
        #1;
        obs_busy = busy;
        if (w_v) begin
            n_fill++; fill_entry = w_entry; fill_vtag = w_vtag; fill_cyc = cyc;
        end
        if (f_instr) n_fi++;
        if (f_load)  n_fl++;
        if (f_store) n_fs++;
        if (mem_req_v && mem_req_ready) begin
            req_q.push_back(mem_req_addr);
            pend_v = 1;
            pend_cnt = resp_delay - 1;
            pend_data = rd(mem_req_addr);
        end
        cyc++;
    endtask

    task automatic walk(input logic [26:0] vt, input logic [27:0] satp,
                        input int typ);
        miss_vtag  = vt;
        satp_ppn   = satp;
        miss_instr = (typ == 0);
        miss_load  = (typ == 1);
        miss_store = (typ == 2);
        clear_obs();
        acc = cyc;
        cycle(1, 0);
        timed_out = 1;
        for (int k = 0; k < 400; k++) begin
            cycle(0, 0);
            if (!obs_busy) begin
                timed_out = 0;
                break;
            end
        end
        idle_rel = cyc - 1 - acc;
    endtask

    task automatic set_path(input logic [27:0] satp, input logic [26:0] vt,
                            input logic [63:0] p2, input logic [63:0] p1,
                            input logic [63:0] p0);
        longint unsigned a;
        mem.delete();
        a = longint'(satp) * 4096 + longint'(vt[26:18]) * 8;
        mem[a[39:0]] = p2;
        a = longint'(p2[37:10]) * 4096 + longint'(vt[17:9]) * 8;
        mem[a[39:0]] = p1;
        a = longint'(p1[37:10]) * 4096 + longint'(vt[8:0]) * 8;
        mem[a[39:0]] = p0;
    endtask

    // Reference: follow Sv39 rules level by level over the PTE map.
    task automatic model(input logic [26:0] vt, input logic [27:0] satp,
                         input bit st);
        longint unsigned base, addr, ppn, span, ptag, vtl;
        logic [63:0] p;
        exp_q.delete();
        exp_fault = 1;
        exp_entry = '0;
        vtl  = vt;
        base = satp;
        for (int lvl = 2; lvl >= 0; lvl--) begin
            addr = base * 4096 + ((vtl >> (9 * lvl)) & 511) * 8;
            exp_q.push_back(addr[39:0]);
            p = rd(addr[39:0]);
            ppn = (p >> 10) & 64'hFFFFFFF;
            if (!p[0] || (!p[1] && p[2])) return;
            if (p[1] || p[3]) begin
                span = 64'd1 << (9 * lvl);
                if (!p[6] || (st && !p[7])) return;
`ifdef BP_PTW_SUPERPAGE_EN
                if (ppn % span != 0) return;
`else
                if (lvl != 0) return;
`endif
                ptag = ppn - ppn % span + vtl % span;
                exp_fault = 0;
                exp_entry = {ptag[27:0], lvl == 2, lvl == 1,
                             p[7], p[4], p[3], p[2], p[1]};
                return;
            end
            if (lvl == 0) return;
            base = ppn;
        end
    endtask

    task automatic test_reset();
        logic [7:0] outs;
        outs = {busy, mem_req_v, w_v, f_instr, f_load, f_store, 2'b00};
        n_tests++;
        if (outs !== 8'h00) begin
            n_fail++; $display("FAIL reset_flags got=%h exp=00", outs);
        end
        n_tests++;
        if (mem_req_addr !== 40'h0) begin
            n_fail++; $display("FAIL reset_addr got=%h exp=0", mem_req_addr);
        end
        n_tests++;
        if (w_vtag !== 27'h0 || w_entry !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_fill got=%h/%h exp=0/0", w_vtag, w_entry);
        end
    endtask

    task automatic test_walk_4k();
        ready_mode = 0; resp_delay = 1;
        set_path(28'h80000, 27'h0012345, mk_pte(44'h80001, FV),
                 mk_pte(44'h80002, FV),
                 mk_pte(44'h0ABCDEF, FV | FR | FW | FA | FD));
        walk(27'h0012345, 28'h80000, 1);
        n_tests++;
        if (timed_out !== 0) begin
            n_fail++; $display("FAIL w4k_timeout got=%0d exp=0", timed_out);
        end
        n_tests++;
        if (req_q.size() !== 3) begin
            n_fail++; $display("FAIL w4k_nreq got=%0d exp=3", req_q.size());
        end else begin
            n_tests++;
            if (req_q[0] !== 40'h80000000 || req_q[1] !== 40'h80001488
                || req_q[2] !== 40'h80002A28) begin
                n_fail++;
                $display("FAIL w4k_addr got=%h %h %h exp=80000000 80001488 80002a28",
                         req_q[0], req_q[1], req_q[2]);
            end
        end
        n_tests++;
        if (n_fill !== 1 || fill_entry !== {28'h0ABCDEF, 7'b0010011}) begin
            n_fail++;
            $display("FAIL w4k_entry got=%0d/%h exp=1/%h", n_fill, fill_entry,
                     {28'h0ABCDEF, 7'b0010011});
        end
        n_tests++;
        if (fill_vtag !== 27'h0012345) begin
            n_fail++; $display("FAIL w4k_vtag got=%h exp=0012345", fill_vtag);
        end
        n_tests++;
        if (fill_cyc - acc !== 7 || idle_rel !== 8) begin
            n_fail++;
            $display("FAIL w4k_timing got=%0d/%0d exp=7/8", fill_cyc - acc, idle_rel);
        end
    endtask

    task automatic test_gigapage();
        ready_mode = 0; resp_delay = 1;
        set_path(28'h80000, 27'h0012345, mk_pte(44'h0040000, FV | FR | FA),
                 64'h0, 64'h0);
        walk(27'h0012345, 28'h80000, 1);
        n_tests++;
        if (req_q.size() !== 1) begin
            n_fail++; $display("FAIL giga_nreq got=%0d exp=1", req_q.size());
        end
`ifdef BP_PTW_SUPERPAGE_EN
        n_tests++;
        if (n_fill !== 1 || fill_entry !== {28'h0052345, 7'b1000001}) begin
            n_fail++;
            $display("FAIL giga_entry got=%0d/%h exp=1/%h", n_fill, fill_entry,
                     {28'h0052345, 7'b1000001});
        end
        n_tests++;
        if (fill_cyc - acc !== 3) begin
            n_fail++; $display("FAIL giga_timing got=%0d exp=3", fill_cyc - acc);
        end
`else
        n_tests++;
        if ({n_fill[1:0], n_fs[1:0], n_fl[1:0], n_fi[1:0]} !== 8'b00000100) begin
            n_fail++;
            $display("FAIL giga_fault got=fill%0d s%0d l%0d i%0d exp=l1",
                     n_fill, n_fs, n_fl, n_fi);
        end
`endif
    endtask

    task automatic test_store_dirty();
        ready_mode = 0; resp_delay = 1;
        set_path(28'h00123, 27'h5555555, mk_pte(44'h00456, FV),
                 mk_pte(44'h00789, FV),
                 mk_pte(44'h0ABCDEF, FV | FR | FW | FA));
        walk(27'h5555555, 28'h00123, 2);
        n_tests++;
        if ({n_fill[1:0], n_fs[1:0], n_fl[1:0], n_fi[1:0]} !== 8'b00010000) begin
            n_fail++;
            $display("FAIL store_d0 got=fill%0d s%0d l%0d i%0d exp=s1",
                     n_fill, n_fs, n_fl, n_fi);
        end
    endtask

    task automatic test_leaf_faults();
        ready_mode = 0; resp_delay = 1;
        set_path(28'h00321, 27'h1234567, mk_pte(44'h00654, FV),
                 mk_pte(44'h00987, FV), mk_pte(44'h00111, FV));
        walk(27'h1234567, 28'h00321, 0);
        n_tests++;
        if (req_q.size() !== 3 || n_fi !== 1 || n_fill !== 0) begin
            n_fail++;
            $display("FAIL nonleaf_l0 got=req%0d i%0d fill%0d exp=3/1/0",
                     req_q.size(), n_fi, n_fill);
        end
        mem.delete();
        walk(27'h1234567, 28'h00321, 0);
        n_tests++;
        if (req_q.size() !== 1 || n_fi !== 1 || n_fill !== 0) begin
            n_fail++;
            $display("FAIL invalid_l2 got=req%0d i%0d fill%0d exp=1/1/0",
                     req_q.size(), n_fi, n_fill);
        end
    endtask

    task automatic test_flush_idle();
        clear_obs();
        miss_load = 1; miss_instr = 0; miss_store = 0;
        cycle(1, 1);
        cycle(0, 0);
        n_tests++;
        if (obs_busy !== 0 || req_q.size() !== 0) begin
            n_fail++;
            $display("FAIL flush_idle got=busy%0d req%0d exp=0/0",
                     obs_busy, req_q.size());
        end
    endtask

    task automatic test_flush_fill();
        ready_mode = 0; resp_delay = 1;
        set_path(28'h80000, 27'h0012345, mk_pte(44'h80001, FV),
                 mk_pte(44'h80002, FV),
                 mk_pte(44'h0ABCDEF, FV | FR | FW | FA | FD));
        miss_vtag = 27'h0012345; satp_ppn = 28'h80000;
        miss_load = 1; miss_instr = 0; miss_store = 0;
        clear_obs();
        cycle(1, 0);
        repeat (6) cycle(0, 0);
        cycle(0, 1);
        cycle(0, 0);
        n_tests++;
        if (n_fill !== 0 || obs_busy !== 0) begin
            n_fail++;
            $display("FAIL flush_fill got=fill%0d busy%0d exp=0/0", n_fill, obs_busy);
        end
    endtask

    task automatic test_flush_wait();
        bit b7, b8;
        ready_mode = 0; resp_delay = 6;
        set_path(28'h80000, 27'h0012345, mk_pte(44'h80001, FV),
                 mk_pte(44'h80002, FV),
                 mk_pte(44'h0ABCDEF, FV | FR | FW | FA | FD));
        miss_vtag = 27'h0012345; satp_ppn = 28'h80000;
        miss_load = 1; miss_instr = 0; miss_store = 0;
        clear_obs();
        cycle(1, 0);
        cycle(0, 0);
        cycle(0, 1);
        repeat (5) cycle(0, 0);
        b7 = obs_busy;
        cycle(0, 0);
        b8 = obs_busy;
        n_tests++;
        if ({b7, b8} !== 2'b10) begin
            n_fail++; $display("FAIL flush_wait_busy got=%b%b exp=10", b7, b8);
        end
        n_tests++;
        if (req_q.size() !== 1 || n_fill !== 0 || n_fl !== 0) begin
            n_fail++;
            $display("FAIL flush_wait_quiet got=req%0d fill%0d l%0d exp=1/0/0",
                     req_q.size(), n_fill, n_fl);
        end
        resp_delay = 1;
        walk(27'h0012345, 28'h80000, 1);
        model(27'h0012345, 28'h80000, 0);
        n_tests++;
        if (req_q.size() !== 3 || n_fill !== 1 || fill_entry !== exp_entry) begin
            n_fail++;
            $display("FAIL flush_wait_rewalk got=req%0d fill%0d %h exp=3/1/%h",
                     req_q.size(), n_fill, fill_entry, exp_entry);
        end
    endtask

    task automatic test_reset_mid_walk();
        logic [5:0] outs;
        ready_mode = 2; resp_delay = 1;
        miss_vtag = 27'h7654321; satp_ppn = 28'h00abc;
        miss_load = 1; miss_instr = 0; miss_store = 0;
        clear_obs();
        cycle(1, 0);
        @(negedge clk);
        miss_v = 0;
        n_tests++;
        if (mem_req_v !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_req got=%b exp=1", mem_req_v);
        end
        reset_n = 1'b0;
        #1;
        outs = {busy, mem_req_v, w_v, f_instr, f_load, f_store};
        n_tests++;
        if (outs !== 6'h00 || mem_req_addr !== 40'h0 || w_entry !== 35'h0
            || w_vtag !== 27'h0) begin
            n_fail++;
            $display("FAIL rst_mid_outs got=%h/%h/%h/%h exp=0", outs,
                     mem_req_addr, w_entry, w_vtag);
        end
        @(negedge clk);
        reset_n = 1'b1;
        pend_v = 0;
        ready_mode = 0;
        set_path(28'h00abc, 27'h7654321, mk_pte(44'h00def, FV),
                 mk_pte(44'h00f00, FV), mk_pte(44'h1234567, FV | FX | FA));
        walk(27'h7654321, 28'h00abc, 0);
        model(27'h7654321, 28'h00abc, 0);
        n_tests++;
        if (req_q.size() !== 3 || req_q[0] !== exp_q[0]
            || fill_entry !== exp_entry) begin
            n_fail++;
            $display("FAIL rst_mid_rewalk got=req%0d %h %h exp=3 %h %h",
                     req_q.size(), req_q[0], fill_entry, exp_q[0], exp_entry);
        end
    endtask

    task automatic build_random(output logic [26:0] vt,
                                output logic [27:0] satp);
        longint unsigned base, addr, vtl;
        logic [43:0] ppn;
        logic [7:0]  fl;
        logic        x, r, w;
        int          k;
        mem.delete();
        vt   = 27'($urandom);
        satp = 28'($urandom);
        vtl  = vt;
        base = satp;
        for (int lvl = 2; lvl >= 0; lvl--) begin
            addr = base * 4096 + ((vtl >> (9 * lvl)) & 511) * 8;
            ppn = {16'($urandom), 28'($urandom)};
            k = $urandom_range(0, 15);
            if (lvl == 0 && k > 9) k = 2;
            if (k == 0) begin
                fl = 8'($urandom) & 8'hFE;
            end else if (k == 1) begin
                fl = (8'($urandom) & 8'hF1) | 8'h05;
            end else if (k <= 5) begin
                x = 1'($urandom);
                r = x ? 1'($urandom) : 1'b1;
                w = r ? 1'($urandom) : 1'b0;
                fl = {1'($urandom), ($urandom_range(0, 3) != 0),
                      1'($urandom), 1'($urandom), x, w, r, 1'b1};
                case ($urandom_range(0, 2))
                    0:       ppn[17:0] = '0;
                    1:       ppn[8:0]  = '0;
                    default: ;
                endcase
            end else begin
                fl = {4'($urandom), 3'b000, 1'b1};
            end
            mem[addr[39:0]] = mk_pte(ppn, fl);
            if (k <= 5) break;
            base = longint'(ppn[27:0]);
        end
    endtask

    task automatic test_random();
        logic [26:0] vt;
        logic [27:0] satp;
        int          typ;
        logic [7:0]  got, exp;
        for (int t = 0; t < 60; t++) begin
            build_random(vt, satp);
            typ = $urandom_range(0, 2);
            ready_mode = 1;
            resp_delay = $urandom_range(1, 3);
            walk(vt, satp, typ);
            model(vt, satp, typ == 2);
            n_tests++;
            if (timed_out !== 0) begin
                n_fail++; $display("FAIL rnd%0d_timeout got=1 exp=0", t);
            end
            n_tests++;
            if (req_q.size() !== exp_q.size()) begin
                n_fail++;
                $display("FAIL rnd%0d_nreq got=%0d exp=%0d", t,
                         req_q.size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    n_tests++;
                    if (req_q[i] !== exp_q[i]) begin
                        n_fail++;
                        $display("FAIL rnd%0d_addr%0d got=%h exp=%h", t, i,
                                 req_q[i], exp_q[i]);
                    end
                end
            end
            got = {n_fill[1:0], n_fs[1:0], n_fl[1:0], n_fi[1:0]};
            exp = !exp_fault ? 8'b01000000
                : (typ == 2) ? 8'b00010000
                : (typ == 1) ? 8'b00000100 : 8'b00000001;
            n_tests++;
            if (got !== exp) begin
                n_fail++; $display("FAIL rnd%0d_outcome got=%b exp=%b", t, got, exp);
            end
            if (!exp_fault) begin
                n_tests++;
                if (fill_entry !== exp_entry || fill_vtag !== vt) begin
                    n_fail++;
                    $display("FAIL rnd%0d_entry got=%h/%h exp=%h/%h", t,
                             fill_entry, fill_vtag, exp_entry, vt);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        satp_ppn = '0; flush = 0; miss_v = 0; miss_vtag = '0;
        miss_instr = 0; miss_load = 0; miss_store = 0;
        mem_req_ready = 0; mem_resp_v = 0; mem_resp_data = '0;
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        test_walk_4k();
        test_gigapage();
        test_store_dirty();
        test_leaf_faults();
        test_flush_idle();
        test_flush_fill();
        test_flush_wait();
        test_reset_mid_walk();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
